cpu_fetch_queue: RTL and testbench
==================================

# cpu_fetch_queue

Parametrised next-generation fetch stage. It decouples instruction-cache fetch from decode with a DEPTH-entry prefetch queue, and fetches back-to-back while the queue has room. Each queued instruction is tagged with its PC, PC+INSTR_BYTES and the predictor decision. It sits between the I-cache and decode. It takes redirects from writeback (trap) and execute (mispredict), which flush the queue and cancel any in-flight fetch.

## Interface
- ADDR_W, 16, PC/address width
- INSTR_W, 16, instruction width
- INSTR_BYTES, 2, PC increment per instruction
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, fetch address after reset

- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_address  out  ADDR_W  I-cache request address; equals pc_q
- i_read  out  1  I-cache request strobe; held with a stable i_address until i_mem_resp
- i_rdata  in  INSTR_W  I-cache data, valid when i_mem_resp=1
- i_mem_resp  in  1  I-cache response, one cycle per request
- bp_taken  in  1  predictor taken decision for i_address (combinational, sampled on i_mem_resp)
- bp_target  in  ADDR_W  predicted target
- trap_redirect  in  1  writeback redirect (highest priority)
- trap_target  in  ADDR_W  trap target
- mis_redirect  in  1  execute mispredict redirect
- mis_target  in  ADDR_W  corrected target
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  head PC
- out_pc_inc  out  ADDR_W  head PC+INSTR_BYTES
- out_pred_taken  out  1  head was predicted taken

## Operation
- Redirect: `redir = trap_redirect | mis_redirect`. Target is trap_target if trap_redirect, else mis_target.
- Pop: on `out_valid & out_ready & !redir`.
- Push: on `i_mem_resp` in FETCH with `!redir`. Entry = {i_rdata, pc_q, pc_q+INSTR_BYTES, bp_taken}.
- Next PC after a push is bp_target if bp_taken, else pc_q+INSTR_BYTES. All address arithmetic is mod 2^ADDR_W.
- Simultaneous push and pop leaves count unchanged. Count width is $clog2(DEPTH)+1.
- Flush on redir: count, head and tail go to 0 on the same edge. A same-cycle pop or push is discarded.
- FSM states:
  - **FETCH**: i_read=1.
    - resp & !redir: push. Stay in FETCH if count_next<DEPTH, else go to WAIT_ROOM.
    - resp & redir: pc_q←target, stay in FETCH.
    - !resp & redir: redir_pc←target, go to DISCARD. pc_q holds so the address stays stable.
  - **DISCARD**: i_read=1 at the old pc_q.
    - A further redir overwrites redir_pc.
    - resp: drop the data. pc_q←redir_pc, or the new target if redir is asserted that same cycle. Go to FETCH.
  - **WAIT_ROOM**: i_read=0.
    - redir: pc_q←target, go to FETCH.
    - Else, when count<DEPTH (a pop occurs): go to FETCH next cycle.
- Reset values: state=FETCH, pc_q=RESET_PC, count/head/tail=0, redir_pc=0. Resulting outputs: i_read=1, i_address=RESET_PC, out_valid=0, and out_instr/out_pc/out_pc_inc/out_pred_taken=0.
- Reset asserted mid-request abandons the request. The cache is expected to be reset by the same reset_n.

## Timing
- Fetch-to-decode latency: i_mem_resp at cycle N gives out_valid=1 at N+1 if the queue was empty.
- Throughput is one instruction per cycle when the cache responds every cycle and decode drains.
- A redirect at cycle N gives out_valid=0 at N+1.
  - From FETCH with resp, or from WAIT_ROOM: i_address=target with i_read=1 at N+1.
  - From FETCH without resp: the target request starts the cycle after the old response.
- Full queue: the response that fills entry DEPTH moves the FSM to WAIT_ROOM. No request is ever issued without a free slot.
- Outputs are driven from registered queue storage. There is no combinational path from i_rdata to the out_* ports.

## Structure
- Add to lc3b_types:
  - `fetch_state_t` enum {FETCH, DISCARD, WAIT_ROOM}
  - `fetch_entry_t` struct {instr, pc, pc_inc, pred_taken} at 16-bit widths, for the default configuration
- Sub-module `fetch_fifo`: parametrised width/DEPTH synchronous FIFO with head/tail/count, push, pop and flush. Flush takes priority.
- cpu_fetch_queue holds the FSM, pc_q, redir_pc and the next-PC mux.

## Test plan
- Reset release, cache responds every cycle, out_ready=1 → i_address 0x0000, 0x0002, 0x0004…; out_pc follows one cycle later; out_pc_inc=out_pc+2.
- out_ready=0, DEPTH=4 → exactly 4 responses accepted, then i_read=0 (WAIT_ROOM). One pop → i_read=1 again the next cycle at 0x0008.
- bp_taken=1, bp_target=0x0040 on the response at 0x0004 → entry pred_taken=1, next i_address=0x0040.
- mis_redirect to 0x0100 while a request at 0x0010 is outstanding without resp → queue empty next cycle, i_address stays 0x0010 until resp, data dropped, next request 0x0100.
- trap_redirect (0x0200) and mis_redirect (0x0100) in the same cycle as a resp and a pop → no push, no pop, count=0, next i_address=0x0200.
- Assert reset_n=0 mid-request with the queue at 3 entries → out_valid=0 and i_address=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_fetch_queue_pkg.sv
// Shared types for the fetch stage: FSM state encoding and the queued entry layout.
package cpu_fetch_queue_pkg;

  typedef enum logic [1:0] {
    FETCH,
    DISCARD,
    WAIT_ROOM
  } fetch_state_t;

  // Entry layout for the default 16-bit configuration; wider builds pack a flat vector.
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic        pred_taken;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/cpu_fetch_queue_if.sv
// Bundle of I-cache, predictor, redirect and decode-side signals of the fetch stage.
interface cpu_fetch_queue_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  i_address;
  logic               i_read;
  logic [INSTR_W-1:0] i_rdata;
  logic               i_mem_resp;
  logic               bp_taken;
  logic [ADDR_W-1:0]  bp_target;
  logic               trap_redirect;
  logic [ADDR_W-1:0]  trap_target;
  logic               mis_redirect;
  logic [ADDR_W-1:0]  mis_target;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [ADDR_W-1:0]  out_pc_inc;
  logic               out_pred_taken;

  modport master (
    output i_address, i_read, out_valid, out_instr, out_pc, out_pc_inc, out_pred_taken,
    input  i_rdata, i_mem_resp, bp_taken, bp_target, trap_redirect, trap_target,
           mis_redirect, mis_target, out_ready
  );

  modport slave (
    input  i_address, i_read, out_valid, out_instr, out_pc, out_pc_inc, out_pred_taken,
    output i_rdata, i_mem_resp, bp_taken, bp_target, trap_redirect, trap_target,
           mis_redirect, mis_target, out_ready
  );
endinterface

// File: rtl/cpu_fetch_queue_fetch_fifo.sv
// Synchronous circular FIFO with flush; flush wins over push and pop on the same edge.
module cpu_fetch_queue_fetch_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push = push_i & (count_q != FULL);
  assign do_pop  = pop_i & (count_q != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + PW'(1);
      if (do_pop)  head_q <= head_q + PW'(1);
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage carries no reset; the consumer qualifies it with valid_o.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[tail_q] <= wdata_i;
  end

  assign rdata_o = mem_q[head_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/cpu_fetch_queue.sv
// Fetch stage: PC/redirect FSM feeding a prefetch queue that decouples I-cache from decode.
module cpu_fetch_queue
  import cpu_fetch_queue_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                INSTR_W     = 16,
  parameter int                INSTR_BYTES = 2,
  parameter int                DEPTH       = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input logic              clk,
  input logic              reset_n,
  cpu_fetch_queue_if.master bus
);
  localparam int                CW     = $clog2(DEPTH) + 1;
  localparam int                EW     = INSTR_W + 2*ADDR_W + 1;
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INSTR_BYTES);
  localparam logic [CW-1:0]     FULL   = CW'(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, redir_pc_q, redir_pc_d;
  logic [ADDR_W-1:0] target, pc_plus;
  logic              redir, push, pop, head_valid, i_read;
  logic [CW-1:0]     count, count_next;
  logic [EW-1:0]     wdata, rdata;

  assign redir      = bus.trap_redirect | bus.mis_redirect;
  assign target     = bus.trap_redirect ? bus.trap_target : bus.mis_target;
  assign pc_plus    = pc_q + PC_INC;
  assign push       = (state_q == FETCH) & bus.i_mem_resp & ~redir;
  assign pop        = head_valid & bus.out_ready & ~redir;
  assign count_next = count + CW'(push) - CW'(pop);
  assign wdata      = {bus.i_rdata, pc_q, pc_plus, bus.bp_taken};

  cpu_fetch_queue_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (redir),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .valid_o (head_valid),
    .count_o (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  // pc_q only moves on a response so the outstanding request address stays stable.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    i_read     = 1'b0;
    case (state_q)
      FETCH: begin
        i_read = 1'b1;
        if (bus.i_mem_resp) begin
          if (redir) begin
            pc_d = target;
          end else begin
            pc_d = bus.bp_taken ? bus.bp_target : pc_plus;
            if (count_next == FULL) state_d = WAIT_ROOM;
          end
        end else if (redir) begin
          redir_pc_d = target;
          state_d    = DISCARD;
        end
      end
      DISCARD: begin
        i_read = 1'b1;
        if (bus.i_mem_resp) begin
          pc_d    = redir ? target : redir_pc_q;
          state_d = FETCH;
        end else if (redir) begin
          redir_pc_d = target;
        end
      end
      WAIT_ROOM: begin
        if (redir) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (count_next != FULL) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.i_read    = i_read;
  assign bus.i_address = pc_q;
  assign bus.out_valid = head_valid;
  assign {bus.out_instr, bus.out_pc, bus.out_pc_inc, bus.out_pred_taken} =
         head_valid ? rdata : '0;

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Directed bench for cpu_fetch_queue with a scoreboard of expected decode-side entries.
module tb_cpu_fetch_queue;
  import cpu_fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cpu_fetch_queue_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

  cpu_fetch_queue #(
    .ADDR_W(16), .INSTR_W(16), .INSTR_BYTES(2), .DEPTH(4), .RESET_PC(16'h0000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int           vectors = 0;
  int           miscompares = 0;
  fetch_entry_t sb[$];
  fetch_entry_t pend;
  bit           push_pending = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Retire the head against the scoreboard, record a pending push, then advance one edge.
  task automatic tick();
    fetch_entry_t e;
    logic r;
    r = bus.trap_redirect | bus.mis_redirect;
    if (r) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_head", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_instr", bus.out_instr, e.instr);
          check("out_pc", bus.out_pc, e.pc);
          check("out_pc_inc", bus.out_pc_inc, e.pc_inc);
          check("out_pred_taken", bus.out_pred_taken, e.pred_taken);
        end
      end
      if (push_pending) sb.push_back(pend);
    end
    push_pending = 0;
    @(posedge clk);
    #1;
    check("out_valid", bus.out_valid, (sb.size() != 0));
  endtask

  task automatic respond(input logic [15:0] addr, input logic [15:0] data, input logic taken,
                         input logic [15:0] tgt, input logic keep);
    check("i_read", bus.i_read, 1'b1);
    check("i_address", bus.i_address, addr);
    bus.i_mem_resp = 1'b1;
    bus.i_rdata    = data;
    bus.bp_taken   = taken;
    bus.bp_target  = tgt;
    if (keep) begin
      pend = '{instr: data, pc: addr, pc_inc: addr + 16'd2, pred_taken: taken};
      push_pending = 1;
    end
    tick();
    bus.i_mem_resp = 1'b0;
    bus.bp_taken   = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.i_mem_resp = 0; bus.i_rdata = '0; bus.bp_taken = 0; bus.bp_target = '0;
    bus.trap_redirect = 0; bus.trap_target = '0; bus.mis_redirect = 0; bus.mis_target = '0;
    bus.out_ready = 0;
    sb.delete();
    push_pending = 0;
    #1;
    check("rst_i_read", bus.i_read, 1'b1);
    check("rst_i_address", bus.i_address, 16'h0000);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_instr", bus.out_instr, 16'h0000);
    check("rst_out_pc", bus.out_pc, 16'h0000);
    check("rst_out_pc_inc", bus.out_pc_inc, 16'h0000);
    check("rst_out_pred", bus.out_pred_taken, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // Streaming: one response per cycle, decode always ready.
    do_reset();
    bus.out_ready = 1;
    for (int k = 0; k < 6; k++) respond(16'(2*k), 16'hA000 + 16'(k), 1'b0, 16'h0, 1'b1);
    tick();
    check("stream_empty", sb.size(), 0);

    // Fill the queue with decode stalled, then free one slot.
    do_reset();
    for (int k = 0; k < 4; k++) respond(16'(2*k), 16'hB000 + 16'(k), 1'b0, 16'h0, 1'b1);
    check("full_i_read", bus.i_read, 1'b0);
    tick();
    check("full_i_read_hold", bus.i_read, 1'b0);
    bus.out_ready = 1;
    tick();
    check("room_i_read", bus.i_read, 1'b1);
    check("room_i_address", bus.i_address, 16'h0008);
    repeat (3) tick();

    // Redirect while waiting for room.
    do_reset();
    for (int k = 0; k < 4; k++) respond(16'(2*k), 16'hB100 + 16'(k), 1'b0, 16'h0, 1'b1);
    check("wr_i_read", bus.i_read, 1'b0);
    bus.mis_redirect = 1; bus.mis_target = 16'h0300;
    tick();
    bus.mis_redirect = 0;
    check("wr_redir_i_read", bus.i_read, 1'b1);
    check("wr_redir_addr", bus.i_address, 16'h0300);

    // Predicted-taken branch.
    do_reset();
    bus.out_ready = 1;
    respond(16'h0000, 16'hC000, 1'b0, 16'h0, 1'b1);
    respond(16'h0002, 16'hC001, 1'b0, 16'h0, 1'b1);
    respond(16'h0004, 16'hC002, 1'b1, 16'h0040, 1'b1);
    respond(16'h0040, 16'hC003, 1'b0, 16'h0, 1'b1);
    respond(16'h0042, 16'hC004, 1'b0, 16'h0, 1'b1);
    tick();

    // Mispredict while a request is outstanding without response.
    do_reset();
    bus.out_ready = 1;
    for (int k = 0; k < 8; k++) respond(16'(2*k), 16'hD000 + 16'(k), 1'b0, 16'h0, 1'b1);
    check("mis_pre_addr", bus.i_address, 16'h0010);
    bus.mis_redirect = 1; bus.mis_target = 16'h0100;
    tick();
    bus.mis_redirect = 0;
    check("disc_i_read", bus.i_read, 1'b1);
    check("disc_addr", bus.i_address, 16'h0010);
    tick();
    check("disc_addr_hold", bus.i_address, 16'h0010);
    respond(16'h0010, 16'hDEAD, 1'b0, 16'h0, 1'b0);
    bus.out_ready = 0;
    respond(16'h0100, 16'hE000, 1'b0, 16'h0, 1'b1);

    // Trap and mispredict together with a response and a pop.
    check("tm_pre_addr", bus.i_address, 16'h0102);
    bus.i_mem_resp = 1; bus.i_rdata = 16'hBAD0;
    bus.trap_redirect = 1; bus.trap_target = 16'h0200;
    bus.mis_redirect = 1; bus.mis_target = 16'h0100;
    bus.out_ready = 1;
    tick();
    bus.i_mem_resp = 0; bus.trap_redirect = 0; bus.mis_redirect = 0;
    check("tm_i_read", bus.i_read, 1'b1);
    check("tm_addr", bus.i_address, 16'h0200);
    respond(16'h0200, 16'hF000, 1'b0, 16'h0, 1'b1);
    tick();

    // Asynchronous reset with three entries queued and a request pending.
    do_reset();
    for (int k = 0; k < 3; k++) respond(16'(2*k), 16'h1000 + 16'(k), 1'b0, 16'h0, 1'b1);
    check("ar_pre_valid", bus.out_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check("ar_out_valid", bus.out_valid, 1'b0);
    check("ar_i_address", bus.i_address, 16'h0000);
    check("ar_out_pc", bus.out_pc, 16'h0000);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
